// File: rtl/prog_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// prog_seq_pkg
//   Shared definitions for the program sequencer: the FSM state encoding,
//   the number of programs in the series, the watchdog limit and the table
//   of program start addresses. The helper functions keep the table lookup
//   and the program-index wrap in one place.
// ---------------------------------------------------------------------------
package prog_seq_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  // Number of programs run in series before prog_idx wraps back to 0
  localparam int NUM_PROGS = 3;

  // Watchdog: a program that has not halted after this many RUN cycles is
  // stopped and flagged with timeout
  localparam int MAX_CYCLES = 64;

  // Entry point of each program in instruction memory
  localparam int START_ADDR [0:NUM_PROGS-1] = '{0, 256, 512};

  // Start address for a program index; an index outside the table falls
  // back to address 0 so the fetch unit never jumps somewhere undefined
  function automatic int start_addr(input logic [1:0] idx);
    if (int'(idx) < NUM_PROGS) begin
      return START_ADDR[idx];
    end
    return 0;
  endfunction

  // Next program in the series, wrapping after the last one
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    if (int'(idx) >= NUM_PROGS - 1) begin
      return 2'd0;
    end
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// ---------------------------------------------------------------------------
// prog_sequencer_if
//   Bundles the signals between the program sequencer, the fetch/decode
//   unit, the core and the bench that requests programs.
//
//   Driven towards the sequencer (master -> slave):
//     start        request to run the next program in the series
//     pc           current PC from the fetch unit
//     halt         decoder has seen a halt instruction at pc
//     core_br_en   core requests a taken branch
//     core_target  core branch destination
//   Driven by the sequencer (slave -> master):
//     branch_en    fetch-unit branch enable
//     target       fetch-unit branch target
//     run          program executing (gates core writes)
//     done         program finished, waiting for start
//     timeout      last program was stopped by the watchdog
//     prog_idx     index of the current or last program
//     cycles       RUN cycles of the current or last program
// ---------------------------------------------------------------------------
interface prog_sequencer_if #(
  parameter int PC_WIDTH  = 11,
  parameter int CYC_WIDTH = 16
);

  logic                 start;
  logic [PC_WIDTH-1:0]  pc;
  logic                 halt;
  logic                 core_br_en;
  logic [PC_WIDTH-1:0]  core_target;

  logic                 branch_en;
  logic [PC_WIDTH-1:0]  target;
  logic                 run;
  logic                 done;
  logic                 timeout;
  logic [1:0]           prog_idx;
  logic [CYC_WIDTH-1:0] cycles;

  // The environment side: bench, fetch unit and core
  modport master (
    output start, pc, halt, core_br_en, core_target,
    input  branch_en, target, run, done, timeout, prog_idx, cycles
  );

  // The sequencer side
  modport slave (
    input  start, pc, halt, core_br_en, core_target,
    output branch_en, target, run, done, timeout, prog_idx, cycles
  );

endinterface

// File: rtl/prog_sequencer_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Up-counter with synchronous clear and enable that sticks at all-ones
//   instead of wrapping, so a very long program never reports a small
//   cycle count.
//
//   Ports:
//     clk     clock, rising edge
//     reset   synchronous active-high reset, clears the count
//     clear   synchronous clear (lower priority than reset)
//     enable  count one step this cycle
//     count   current count value
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  // Clear wins over enable; once all-ones the count holds
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// ---------------------------------------------------------------------------
// prog_sequencer
//   Runs a series of test programs on a core. Each start request loads the
//   next program's entry address into the fetch unit, lets the core run
//   until the decoder reports halt (or the watchdog expires), then freezes
//   the PC and waits for the next start.
//
//   Ports:
//     clk    clock, rising edge
//     reset  synchronous active-high reset, overrides everything
//     bus    prog_sequencer_if slave modport (handshake, fetch and core
//            signals, status outputs)
// ---------------------------------------------------------------------------
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int PC_WIDTH  = 11,
  parameter int CYC_WIDTH = 16
) (
  input logic             clk,
  input logic             reset,
  prog_sequencer_if.slave bus
);

  seq_state_t           state;
  logic                 run_q;
  logic                 done_q;
  logic                 timeout_q;
  logic [1:0]           idx_q;
  logic [CYC_WIDTH-1:0] cycle_count;

  logic                 count_clear;
  logic                 count_en;
  logic                 at_limit;

  // The count is zeroed while in LOAD so the new program starts from 0.
  // The halt cycle itself is not counted: halt at the n-th instruction
  // reports n cycles of useful work.
  assign count_clear = (state == LOAD);
  assign count_en    = (state == RUN) && !bus.halt;
  assign at_limit    = (cycle_count == CYC_WIDTH'(MAX_CYCLES - 1));

  sat_counter #(
    .WIDTH (CYC_WIDTH)
  ) u_cycle_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (count_clear),
    .enable (count_en),
    .count  (cycle_count)
  );

  // Sequencer FSM. run/done are decoded from the next state here so they
  // come straight out of flops. prog_idx moves only when a start is taken
  // from DONE; the very first start after reset runs program 0. timeout is
  // cleared in LOAD so it keeps describing the previous program through
  // DONE and the LOAD cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      idx_q     <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= LOAD;
            idx_q <= 2'd0;
          end
        end

        LOAD: begin
          state     <= RUN;
          run_q     <= 1'b1;
          timeout_q <= 1'b0;
        end

        RUN: begin
          if (bus.halt) begin
            state  <= DONE;
            run_q  <= 1'b0;
            done_q <= 1'b1;
          end else if (at_limit) begin
            state     <= DONE;
            run_q     <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end

        DONE: begin
          if (bus.start) begin
            state  <= LOAD;
            done_q <= 1'b0;
            idx_q  <= next_idx(idx_q);
          end
        end

        default: begin
          state  <= IDLE;
          run_q  <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // Fetch-unit steering. Outside RUN the PC is held by branching to itself,
  // LOAD jumps to the program entry, and in RUN the core's branch request
  // passes straight through unless halt is seen, in which case the PC is
  // pinned at the halt instruction regardless of any core branch.
  always_comb begin
    bus.branch_en = 1'b1;
    bus.target    = bus.pc;
    case (state)
      LOAD: begin
        bus.target = PC_WIDTH'(start_addr(idx_q));
      end
      RUN: begin
        if (!bus.halt) begin
          bus.branch_en = bus.core_br_en;
          bus.target    = bus.core_target;
        end
      end
      default: begin
        bus.branch_en = 1'b1;
        bus.target    = bus.pc;
      end
    endcase
  end

  assign bus.run      = run_q;
  assign bus.done     = done_q;
  assign bus.timeout  = timeout_q;
  assign bus.prog_idx = idx_q;
  assign bus.cycles   = cycle_count;

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 The module SHALL have parameter PC_WIDTH, default 11, setting the program-counter width.
REQ-002 The module SHALL have parameter CYC_WIDTH, default 16, setting the cycle-counter width.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The module SHALL have port start, input, 1, a bench request to run the next program in the series.
REQ-006 The module SHALL have port pc, input, PC_WIDTH, the current PC from the fetch unit.
REQ-007 The module SHALL have port halt, input, 1, meaning the decoder has seen a halt instruction at pc.
REQ-008 The module SHALL have port core_br_en, input, 1, meaning the core requests a taken branch.
REQ-009 The module SHALL have port core_target, input, PC_WIDTH, the core branch destination.
REQ-010 The module SHALL have port branch_en, output, 1, driven to the fetch-unit branch enable.
REQ-011 The module SHALL have port target, output, PC_WIDTH, driven to the fetch-unit target.
REQ-012 The module SHALL have port run, output, 1, high while a program executes; it gates core writes.
REQ-013 The module SHALL have port done, output, 1, high while the program is finished and awaiting start.
REQ-014 The module SHALL have port timeout, output, 1, meaning the last program ended by watchdog and not by halt.
REQ-015 The module SHALL have port prog_idx, output, 2, the index of the current or last program, 0..NUM_PROGS-1.
REQ-016 The module SHALL have port cycles, output, CYC_WIDTH, the number of RUN cycles of the current or last program.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, RUN and DONE.
REQ-018 In IDLE and DONE, branch_en SHALL be 1 and target SHALL equal pc, so the PC holds.
REQ-019 In IDLE and DONE, a start pulse SHALL move the FSM to LOAD on the next edge.
REQ-020 On a start accepted from DONE, prog_idx SHALL advance by one, wrapping from NUM_PROGS-1 to 0.
REQ-021 On a start accepted from IDLE, prog_idx SHALL stay 0.
REQ-022 LOAD SHALL last exactly one cycle, with branch_en=1 and target=START_ADDR[prog_idx].
REQ-023 LOAD SHALL clear cycles and timeout, then go to RUN.
REQ-024 In RUN, branch_en SHALL equal core_br_en and target SHALL equal core_target, both combinational pass-through.
REQ-025 In RUN, cycles SHALL increment by 1 each cycle, saturating at all-ones.
REQ-026 In RUN with halt=1, the FSM SHALL go to DONE; in that cycle branch_en=1 and target=pc, so pc is frozen at the halt address.
REQ-027 If halt and core_br_en are both high in RUN, halt SHALL win.
REQ-028 In RUN, if cycles reaches MAX_CYCLES-1 without halt, the FSM SHALL go to DONE with timeout=1.
REQ-029 run SHALL equal 1 only in RUN; done SHALL equal 1 only in DONE. Both SHALL be registered state decodes.
REQ-030 start SHALL be ignored in LOAD and RUN.
REQ-031 cycles, timeout and prog_idx SHALL hold their values through DONE until the next LOAD.

Reset
REQ-032 reset SHALL be synchronous and active-high, and SHALL take priority over every other input.
REQ-033 On reset the FSM SHALL enter IDLE with run=0, done=0, timeout=0, prog_idx=0 and cycles=0.
REQ-034 Reset asserted mid-RUN SHALL abort the program with no done pulse.
REQ-035 In the cycle after reset, outputs SHALL follow IDLE rules (branch_en=1, target=pc).

Structure
REQ-036 Package prog_seq_pkg SHALL hold the state enum, NUM_PROGS=3, MAX_CYCLES and the START_ADDR table {0, 256, 512}.
REQ-037 The cycle counter SHALL be a separate sub-module, sat_counter, with clear, enable and saturate behaviour.
REQ-038 The FSM and output muxing SHALL reside in prog_sequencer.

Verification
REQ-039 Reset, then start pulse: the bench SHALL see LOAD with target=0, then RUN next cycle; pc at fetch SHALL become 0 and increment each cycle.
REQ-040 Halt at pc=20 after 20 RUN cycles: the bench SHALL see done=1, cycles=20, timeout=0, and pc held at 20 for 10 idle cycles.
REQ-041 Second and third starts: target SHALL be 256 then 512 in LOAD; a fourth start SHALL wrap prog_idx to 0 with target=0.
REQ-042 core_br_en=1 with core_target=100 in RUN: branch_en=1 and target=100 same cycle; halt and core_br_en together SHALL give DONE with target=pc.
REQ-043 No halt for MAX_CYCLES cycles: the bench SHALL see done=1 and timeout=1; a start pulse during RUN SHALL have no effect.
REQ-044 Reset asserted mid-RUN at cycle 7: the bench SHALL see IDLE next cycle with run=0, done=0, cycles=0 and prog_idx=0.
